ifetch_buf: RTL
===============

IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, fetch buffer entries (fixed at 2 for this revision).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  instruction memory read request this cycle.
REQ-006 SHALL have port imem_addr  output  32  word-aligned read address; meaningful when imem_req=1.
REQ-007 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_req=1.
REQ-008 SHALL have port redirect  input  1  taken branch/jump from npc logic; flush and refetch.
REQ-009 SHALL have port redirect_pc  input  32  new fetch target; sampled when redirect=1.
REQ-010 SHALL have port id_ready  input  1  decode accepts id_inst this cycle (0 = hazard stall).
REQ-011 SHALL have port id_valid  output  1  id_inst/id_pc/id_pc4 hold a real instruction.
REQ-012 SHALL have port id_inst  output  32  instruction to decode; 32'h0 when id_valid=0.
REQ-013 SHALL have port id_pc  output  32  address of id_inst; 32'h0 when id_valid=0.
REQ-014 SHALL have port id_pc4  output  32  id_pc+4; 32'h0 when id_valid=0.

Function
REQ-015 SHALL hold pc_q (next sequential fetch address), inflight_q (1 bit), inflight_pc_q (32) and a 2-entry FIFO of {pc, inst} with count 0..2.
REQ-016 SHALL define pop = id_valid & id_ready; the FIFO head leaves on pop.
REQ-017 SHALL drive imem_req=1 when rst=0 and (redirect=1 or count+inflight_q-pop < 2); otherwise 0.
REQ-018 SHALL drive imem_addr = {redirect_pc[31:2],2'b00} when redirect=1, else pc_q.
REQ-019 SHALL, on each issued request, set pc_q <= imem_addr+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0), inflight_q <= 1, inflight_pc_q <= imem_addr; with no request, inflight_q <= 0.
REQ-020 SHALL, when inflight_q=1 and redirect=0, push {inflight_pc_q, imem_rdata} into the FIFO tail that cycle.
REQ-021 SHALL allow push and pop in the same cycle; count changes by push-pop; REQ-017 guarantees no push into a full FIFO.
REQ-022 SHALL present the FIFO head combinationally: id_valid = (count!=0) & ~redirect.
REQ-023 SHALL, on redirect=1, clear the FIFO (count<=0), discard the response arriving that cycle, and issue the request at redirect_pc in the same cycle; redirect beats push, pop and stall.
REQ-024 SHALL give latency 2: request in cycle N -> id_valid with that instruction in cycle N+2 if the FIFO was empty.
REQ-025 SHALL sustain one instruction per cycle while id_ready=1 and no redirect.
REQ-026 SHALL hold id_inst/id_pc stable while id_valid=1 and id_ready=0.
REQ-027 SHALL keep back-to-back redirects correct: each redirect discards everything prior, only the last target's stream is delivered.

Reset
REQ-028 SHALL, while rst=1, set pc_q<=RESET_PC, count<=0, inflight_q<=0, and drive imem_req=0, id_valid=0, id_inst/id_pc/id_pc4=0.
REQ-029 SHALL, on first cycle with rst=0, issue a request at RESET_PC; rst asserted mid-stream discards all buffered and in-flight data.

Structure
REQ-030 SHALL take RESET_PC default, DEPTH, and the null-instruction constant 32'h0 from the shared pipeline package used by decode.
REQ-031 SHALL implement the buffer as one sub-module if_fifo (2-entry, push/pop/flush, count output); request/PC logic stays in ifetch_buf.

Verification
REQ-032 SHALL cover reset release with id_ready=1, memory returning addr-as-data: imem_addr 0,4,8... from cycle 0; id_valid first high cycle 2 with id_pc=0, then one instruction per cycle.
REQ-033 SHALL cover stall: id_ready=0 for 5 cycles at id_pc=8 -> id_pc stays 8, count reaches 2, imem_req drops to 0; release -> id_pc 8,12,16 consecutive.
REQ-034 SHALL cover redirect to 32'h0000_0100 with full FIFO -> id_valid=0 that cycle, imem_addr=0x100, next delivered id_pc=0x100 two cycles later, no stale pc delivered.
REQ-035 SHALL cover misaligned redirect_pc=32'h0000_0206 -> imem_addr=0x204; and pc_q wrap from 32'hFFFF_FFFC -> next fetch 0.
REQ-036 SHALL cover redirects in two consecutive cycles (0x40 then 0x80) and rst pulse mid-stream -> only 0x80 stream, resp. RESET_PC stream, delivered.

Source files
------------

// File: rtl/ifetch_buf_pkg.sv
// Shared pipeline definitions for the fetch buffer and decode.
// The reset PC default, buffer depth and null instruction live here so decode agrees with fetch.
package ifetch_buf_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_DEPTH      = 2;
  localparam logic [31:0] NULL_INST        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_buf_if_fifo.sv
// Small {pc, inst} FIFO between instruction memory and decode.
// Flush is synchronous and takes priority over push and pop.
module if_fifo
  import ifetch_buf_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [CW-1:0]  count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch: issues word reads, buffers responses in if_fifo and feeds decode.
// A redirect flushes everything and refetches from the new target in the same cycle.
module ifetch_buf
  import ifetch_buf_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          push;
  logic          flush;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Occupancy counts buffered entries plus the one in flight, less the one leaving now,
  // so a request is only issued when its response is guaranteed a free slot.
  always_comb begin
    id_valid   = (count != '0) & ~redirect & ~rst;
    pop        = id_valid & id_ready;
    occupancy  = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req   = ~rst & (redirect | (occupancy < (CW+1)'(DEPTH)));
    imem_addr  = redirect ? align_word(redirect_pc) : pc_q;
    push       = inflight_q & ~redirect & ~rst;
    flush      = rst | redirect;
    push_entry = '{pc: inflight_pc_q, inst: imem_rdata};
    id_inst    = id_valid ? head.inst : NULL_INST;
    id_pc      = id_valid ? head.pc : 32'h0;
    id_pc4     = id_valid ? head.pc + 32'd4 : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else if (imem_req) begin
      pc_q          <= imem_addr + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= imem_addr;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

endmodule
